// File: rtl/write_operation.sv
// Write side of the 8x32 register file: valid/ready request FIFO, one commit per cycle.
// Ports: clk, reset_n, wr_valid/wr_ready, Addr, Data, wr_be, wr_done, busy, to_reg0..7.
// Optional build macro WRITE_OP_ZERO_REG_EN: register 0 reads as zero and ignores writes.
module write_operation #(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [2:0]  Addr,
  input  logic [31:0] Data,
  input  logic [3:0]  wr_be,
  output logic        wr_done,
  output logic        busy,
  output logic [31:0] to_reg0,
  output logic [31:0] to_reg1,
  output logic [31:0] to_reg2,
  output logic [31:0] to_reg3,
  output logic [31:0] to_reg4,
  output logic [31:0] to_reg5,
  output logic [31:0] to_reg6,
  output logic [31:0] to_reg7
);

`ifdef WRITE_OP_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  typedef struct packed {
    logic [2:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_req_t;

  wr_req_t       fifo_q [DEPTH];
  wr_req_t       head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   regs [8];
  logic          push;
  logic          pop;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign wr_ready = (count != FULL);
  assign push     = wr_valid && wr_ready;
  assign pop      = (count != '0);
  assign busy     = pop;
  assign head     = fifo_q[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++)
        fifo_q[i] <= '0;
    end else if (push) begin
      fifo_q[wr_ptr] <= '{addr: Addr,
                         data: Data,
                         be:   wr_be};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      wr_done <= 1'b0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      unique case (1'b1)
        (push && !pop): count <= count + 1'b1;
        (pop && !push): count <= count - 1'b1;
        default:        count <= count;
      endcase
      wr_done <= pop;
    end
  end

  // With the zero-register build, slot 0 resets to zero and
  // is never written, so it folds to a constant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < 8; r++)
        regs[r] <= (ZERO_REG && r == 0) ? 32'h0 : RESET_VAL;
    end else if (pop && !(ZERO_REG && head.addr == 3'd0)) begin
      for (int b = 0; b < 4; b++)
        if (head.be[b])
          regs[head.addr][8*b +: 8] <= head.data[8*b +: 8];
    end
  end

  assign to_reg0 = regs[0];
  assign to_reg1 = regs[1];
  assign to_reg2 = regs[2];
  assign to_reg3 = regs[3];
  assign to_reg4 = regs[4];
  assign to_reg5 = regs[5];
  assign to_reg6 = regs[6];
  assign to_reg7 = regs[7];

endmodule
